// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: bitstream word valid/ready bus
// master drives word_in/word_valid and samples word_ready; slave is the loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  modport master (output word_in, word_valid, input word_ready);
  modport slave  (input word_in, word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words MSB-first onto a config DFF chain
// ports: prog_clk/prog_reset (async, active-high); start begins a load (IDLE/DONE only);
// bus carries word_in/word_valid/word_ready; ccff_head/shift_en are registered chain drives;
// busy/done report load status; bit_count counts bits shifted in the current load.
module ccff_chain_loader #(
  parameter  int WORD_W    = 8,
  parameter  int CHAIN_LEN = 30,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 start,
  ccff_chain_loader_if.slave   bus,
  output logic                 ccff_head,
  output logic                 shift_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bit_count
);
  localparam int LW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [LW-1:0]     left_q, left_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d, rem;
  logic              ccff_head_q, ccff_head_d, shift_en_q, shift_en_d;
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    left_d      = left_q;
    bit_count_d = bit_count_q;
    ccff_head_d = ccff_head_q;
    shift_en_d  = 1'b0;
    rem         = CNT_W'(CHAIN_LEN) - bit_count_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d     = FETCH;
        bit_count_d = '0;
      end
      FETCH: if (bus.word_valid) begin
        shreg_d = bus.word_in;
        // a final partial word only shifts the bits the chain still needs
        left_d  = (32'(rem) > 32'(WORD_W)) ? LW'(WORD_W) : LW'(rem);
        state_d = SHIFT;
      end
      SHIFT: begin
        ccff_head_d = shreg_q[WORD_W-1];
        shift_en_d  = 1'b1;
        shreg_d     = shreg_q << 1;
        bit_count_d = bit_count_q + CNT_W'(1);
        left_d      = left_q - LW'(1);
        if (left_q == LW'(1)) state_d = (bit_count_d == CNT_W'(CHAIN_LEN)) ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      left_q      <= '0;
      bit_count_q <= '0;
      ccff_head_q <= 1'b0;
      shift_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      left_q      <= left_d;
      bit_count_q <= bit_count_d;
      ccff_head_q <= ccff_head_d;
      shift_en_q  <= shift_en_d;
    end
  end
  assign bus.word_ready = state_q == FETCH;
  assign busy           = (state_q == FETCH) || (state_q == SHIFT);
  assign done           = state_q == DONE;
  assign ccff_head      = ccff_head_q;
  assign shift_en       = shift_en_q;
  assign bit_count      = bit_count_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed bench for the chain loader with downstream chain models
module tb_ccff_chain_loader;
  logic prog_clk = 1'b0, prog_reset = 1'b1, start = 1'b0, start3 = 1'b0;
  always #5 prog_clk = ~prog_clk;
  ccff_chain_loader_if #(.WORD_W(8)) b30 ();
  ccff_chain_loader_if #(.WORD_W(8)) b3 ();
  logic       head30, sen30, busy30, done30, head3, sen3, busy3, done3;
  logic [4:0] cnt30;
  logic [1:0] cnt3;
  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(30)) dut30 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .bus(b30),
    .ccff_head(head30), .shift_en(sen30), .busy(busy30), .done(done30), .bit_count(cnt30));
  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(3)) dut3 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start3), .bus(b3),
    .ccff_head(head3), .shift_en(sen3), .busy(busy3), .done(done3), .bit_count(cnt3));
  localparam logic [29:0] EXP = {8'hA5, 8'h3C, 8'hFF, 6'b100000};
  logic [29:0] chain30 = '0;
  logic [2:0]  chain3 = '0;
  int shifts30 = 0, shifts3 = 0;
  int vectors = 0, miscompares = 0;
  always @(posedge prog_clk) begin
    if (sen30) begin
      chain30  <= {chain30[28:0], head30};
      shifts30 <= shifts30 + 1;
    end
    if (sen3) begin
      chain3  <= {chain3[1:0], head3};
      shifts3 <= shifts3 + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge prog_clk);
    #1;
  endtask
  task automatic wait_ready(input string tag);
    for (int k = 0; k < 40 && b30.word_ready !== 1'b1; k++) cyc();
    check(tag, b30.word_ready, 1);
  endtask
  task automatic load30(input bit stall, input bit poke);
    logic [7:0]  w [4];
    logic [29:0] snap;
    int          s0;
    w  = '{8'hA5, 8'h3C, 8'hFF, 8'h81};
    s0 = shifts30;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("ld_busy", busy30, 1);
    check("ld_done_clr", done30, 0);
    check("ld_ready", b30.word_ready, 1);
    check("ld_cnt0", cnt30, 0);
    for (int i = 0; i < 4; i++) begin
      wait_ready("ready_timeout");
      check("cnt_at_fetch", cnt30, 8 * i);
      if (stall && i == 2) begin
        cyc();
        snap = chain30;
        for (int k = 0; k < 5; k++) begin
          check("stall_sen", sen30, 0);
          cyc();
        end
        check("stall_chain", chain30, snap);
        check("stall_ready", b30.word_ready, 1);
      end
      b30.word_in = w[i];
      b30.word_valid = 1'b1;
      cyc();
      b30.word_valid = 1'b0;
      b30.word_in = '0;
      if (poke && i == 0) begin
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("poke_ready", b30.word_ready, 0);
        check("poke_busy", busy30, 1);
        check("poke_cnt", cnt30, 2);
      end
    end
    for (int k = 0; k < 40 && done30 !== 1'b1; k++) cyc();
    check("done_timeout", done30, 1);
    cyc();
    check("done_hold", done30, 1);
    check("final_cnt", cnt30, 30);
    check("final_sen", sen30, 0);
    check("final_busy", busy30, 0);
    check("final_ready", b30.word_ready, 0);
    check("head_hold", head30, 0);
    check("shift_count", shifts30 - s0, 30);
    check("stream", chain30, EXP);
    check("tail", chain30[29], 1);
  endtask
  initial begin
    b30.word_in = '0;
    b30.word_valid = 1'b0;
    b3.word_in = '0;
    b3.word_valid = 1'b0;
    repeat (3) cyc();
    check("rst_sen", sen30, 0);
    check("rst_head", head30, 0);
    check("rst_busy", busy30, 0);
    check("rst_done", done30, 0);
    check("rst_ready", b30.word_ready, 0);
    check("rst_cnt", cnt30, 0);
    check("rst_sen3", sen3, 0);
    prog_reset = 1'b0;
    b30.word_valid = 1'b1;
    cyc();
    b30.word_valid = 1'b0;
    check("idle_valid_ready", b30.word_ready, 0);
    check("idle_valid_busy", busy30, 0);
    load30(1'b0, 1'b0);
    load30(1'b1, 1'b0);
    load30(1'b0, 1'b1);
    start3 = 1'b1;
    cyc();
    start3 = 1'b0;
    check("c3_ready", b3.word_ready, 1);
    b3.word_in = 8'hC0;
    b3.word_valid = 1'b1;
    cyc();
    b3.word_valid = 1'b0;
    check("c3_sen_lat", sen3, 0);
    cyc();
    check("c3_b0_sen", sen3, 1);
    check("c3_b0", head3, 1);
    cyc();
    check("c3_b1_sen", sen3, 1);
    check("c3_b1", head3, 1);
    cyc();
    check("c3_b2_sen", sen3, 1);
    check("c3_b2", head3, 0);
    cyc();
    check("c3_sen_off", sen3, 0);
    check("c3_done", done3, 1);
    check("c3_busy", busy3, 0);
    check("c3_cnt", cnt3, 3);
    check("c3_shifts", shifts3, 3);
    check("c3_mem", chain3, 3'b110);
    check("c3_tail", chain3[2], 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_ready("r5_ready0");
    b30.word_in = 8'hA5;
    b30.word_valid = 1'b1;
    cyc();
    b30.word_valid = 1'b0;
    wait_ready("r5_ready1");
    b30.word_in = 8'h3C;
    b30.word_valid = 1'b1;
    cyc();
    b30.word_valid = 1'b0;
    for (int k = 0; k < 40 && cnt30 !== 5'd12; k++) cyc();
    check("r5_cnt12", cnt30, 12);
    prog_reset = 1'b1;
    #1;
    check("r5_sen", sen30, 0);
    check("r5_busy", busy30, 0);
    check("r5_done", done30, 0);
    check("r5_ready", b30.word_ready, 0);
    check("r5_cnt", cnt30, 0);
    cyc();
    prog_reset = 1'b0;
    cyc();
    load30(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
